// File: rtl/banco_registros_param.sv
// ---------------------------------------------------------------------------
// banco_registros_param
// Multi-port register file for the datapath: DEPTH x WIDTH storage, two
// synchronous write ports (B wins on same-address collision), two purely
// combinational read ports, optional hardwired-zero register 0, optional
// same-cycle write-to-read forwarding, synchronous clear, and a registered
// "written since clear" flag per register.
//
// Handshake: there is none. Every write port is a plain enable; an enabled
// write with a valid address is committed at the next rising clock edge
// unless clr or rst is active. Reads have no latency.
// ---------------------------------------------------------------------------
module banco_registros_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we_a,
    input  logic [AW-1:0]    addr_wr_a,
    input  logic [WIDTH-1:0] din_a,
    input  logic             we_b,
    input  logic [AW-1:0]    addr_wr_b,
    input  logic [WIDTH-1:0] din_b,
    input  logic [AW-1:0]    addr_rd1,
    input  logic [AW-1:0]    addr_rd2,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [DEPTH-1:0] dirty
);

    // DEPTH need not be a power of two, so an AW-bit address can point past
    // the last register. Compare with one extra bit so DEPTH itself fits.
    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             addr_ok_a;
    logic             addr_ok_b;
    logic             zero_hit_a;
    logic             zero_hit_b;
    logic             wr_eff_a;
    logic             wr_eff_b;
    logic [DEPTH-1:0] hit_a;
    logic [DEPTH-1:0] hit_b;
    logic [WIDTH-1:0] stored1;
    logic [WIDTH-1:0] stored2;

    // A write is "effective" only when enabled, in range, and not aimed at a
    // hardwired-zero register 0. clr is handled separately because it also
    // suppresses forwarding, not just storage.
    always_comb begin
        addr_ok_a  = ({1'b0, addr_wr_a} < DEPTH_LIM);
        addr_ok_b  = ({1'b0, addr_wr_b} < DEPTH_LIM);
        zero_hit_a = (ZERO_REG != 0) && (addr_wr_a == '0);
        zero_hit_b = (ZERO_REG != 0) && (addr_wr_b == '0);
        wr_eff_a   = we_a && addr_ok_a && !zero_hit_a;
        wr_eff_b   = we_b && addr_ok_b && !zero_hit_b;
    end

    // Per-register write decode for each port.
    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_a[i] = wr_eff_a && (addr_wr_a == AW'(i));
            hit_b[i] = wr_eff_b && (addr_wr_b == AW'(i));
        end
    end

    // Storage update: rst > clr > writes; port B overrides port A on the
    // same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit_b[i]) begin
                    mem[i] <= din_b;
                end else if (hit_a[i]) begin
                    mem[i] <= din_a;
                end
            end
        end
    end

    // Written-since-clear flags: set only by effective writes, cleared only
    // by rst or clr. A collision sets the flag once, same as a single write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dirty <= '0;
        end else if (clr) begin
            dirty <= '0;
        end else begin
            dirty <= dirty | hit_a | hit_b;
        end
    end

    // Stored-value mux for both read ports. An out-of-range address matches
    // no register and so reads as zero.
    always_comb begin
        stored1 = '0;
        stored2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_rd1 == AW'(i)) begin
                stored1 = mem[i];
            end
            if (addr_rd2 == AW'(i)) begin
                stored2 = mem[i];
            end
        end
    end

    // Final read value for one port: zero register first, then forwarding
    // (B over A, disabled while clr is active), else the stored value.
    function automatic logic [WIDTH-1:0] read_sel(
        input logic [AW-1:0]    addr,
        input logic [WIDTH-1:0] stored,
        input logic             fwd_en,
        input logic             eff_a,
        input logic [AW-1:0]    wa_addr,
        input logic [WIDTH-1:0] wa_data,
        input logic             eff_b,
        input logic [AW-1:0]    wb_addr,
        input logic [WIDTH-1:0] wb_data
    );
        logic [WIDTH-1:0] r;
        r = stored;
        if ((ZERO_REG != 0) && (addr == '0)) begin
            r = '0;
        end else if (fwd_en && eff_b && (wb_addr == addr)) begin
            r = wb_data;
        end else if (fwd_en && eff_a && (wa_addr == addr)) begin
            r = wa_data;
        end
        return r;
    endfunction

    logic fwd_en;

    // Forwarding is a build-time option and is suppressed during clear so
    // the outputs show the contents that are about to be wiped.
    always_comb begin
        fwd_en = (BYPASS != 0) && !clr;
        dout1  = read_sel(addr_rd1, stored1, fwd_en,
                          wr_eff_a, addr_wr_a, din_a,
                          wr_eff_b, addr_wr_b, din_b);
        dout2  = read_sel(addr_rd2, stored2, fwd_en,
                          wr_eff_a, addr_wr_a, din_a,
                          wr_eff_b, addr_wr_b, din_b);
    end

endmodule
